x_bitmap_stream_scheduler: RTL and testbench

Next-generation scheduler for sparse matrix X (row-major bitmap plus packed nonzeros) in the Gustavson dataflow. Replaces the unbounded per-cycle bitmap scan with a bounded SCAN_W-bit-per-cycle scanner and an explicit FSM. Uses a valid/ready handshake towards the streamer and a separate nonzero base address. Sits between the controller (start/params) and the X streamer address generator; metadata chunks are returned from the metadata streamer.

---
 rtl/x_bitmap_stream_scheduler.sv | 271 +++++++++++++++++++++++++++
 tb/tb_x_bitmap_stream_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_bitmap_stream_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : x_bitmap_stream_scheduler                                    |
// | Description : Bounded-scan bitmap scheduler for sparse X (Gustavson flow).  |
// |               Optional perf counters enabled by macro X_SCHED_PERF_EN.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module x_bitmap_stream_scheduler #(
  parameter int BW              = 128,
  parameter int DATA_SIZE       = 32,
  parameter int META_CHUNK_SIZE = 32,
  parameter int SCAN_W          = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       start_i,
  input  logic [31:0]                meta_base_i,
  input  logic [31:0]                nz_base_i,
  input  logic [15:0]                x_rows_i,
  input  logic [15:0]                x_cols_i,
  input  logic [4:0]                 x_cols_log_i,
  input  logic [15:0]                y_row_iters_i,
  input  logic                       meta_valid_i,
  input  logic [META_CHUNK_SIZE-1:0] meta_chunk_i,
  output logic                       cfg_valid_o,
  input  logic                       cfg_ready_i,
  output logic                       cfg_is_meta_o,
  output logic [31:0]                cfg_addr_o,
  output logic [15:0]                cfg_len_o,
  output logic [15:0]                cfg_stride_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [31:0]                perf_meta_req_o,
  output logic [31:0]                perf_data_req_o,
  output logic [31:0]                perf_stall_o
);
  localparam int c_max_elems = (BW / DATA_SIZE > 1) ? BW / DATA_SIZE : 1;
  localparam int c_bp_w      = $clog2(META_CHUNK_SIZE) + 1;
  localparam int c_bc_w      = $clog2(c_max_elems + 1);
  localparam logic [c_bc_w-1:0] c_max_bc     = c_bc_w'(c_max_elems);
  localparam logic [c_bp_w-1:0] c_chunk_bits = c_bp_w'(META_CHUNK_SIZE);
  localparam logic [15:0]       c_meta_bytes = 16'(META_CHUNK_SIZE / 8);
  localparam logic [15:0]       c_data_bytes = 16'(DATA_SIZE / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_META_REQ, S_META_WAIT, S_SCAN, S_DATA_REQ, S_DONE
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic [31:0]                r_meta_base, r_nz_base;
  logic [15:0]                r_x_rows, r_x_cols, r_y_iters;
  logic [4:0]                 r_x_cols_log;
  logic [META_CHUNK_SIZE-1:0] r_chunk;
  logic [15:0]                r_row, r_pass, r_col, w_row_nxt, w_pass_nxt, w_col_nxt;
  logic [c_bp_w-1:0]          r_bit_ptr, w_bit_ptr_nxt;
  logic [31:0]                r_nz_ptr, r_nz_row_start, w_nz_ptr_nxt, w_nz_row_start_nxt;
  logic [c_bc_w-1:0]          r_batch_cnt, w_batch_cnt_nxt;

  logic [31:0]       w_bit_addr;
  logic [16:0]       w_rem_bits, w_rem_bytes;
  logic [15:0]       w_last_stride;
  logic [SCAN_W-1:0] w_window;
  logic [16:0]       w_lim;
  logic [c_bp_w-1:0] w_k, w_scan_bp;
  logic [c_bc_w-1:0] w_pop, w_scan_batch;
  logic [15:0]       w_scan_col;
  logic              w_hit, w_flush, w_adv;
  logic [31:0]       w_adv_nz;

  assign w_bit_addr    = ({16'd0, r_row} << r_x_cols_log) + {16'd0, r_col};
  assign w_rem_bits    = 17'(w_bit_addr[2:0]) + {1'b0, r_x_cols} - {1'b0, r_col};
  assign w_rem_bytes   = (w_rem_bits + 17'd7) >> 3;
  assign w_last_stride = (w_rem_bytes < {1'b0, c_meta_bytes}) ? w_rem_bytes[15:0] : c_meta_bytes;

  // Consume bits until the window, chunk or row ends, or the batch fills up.
  always_comb begin
    w_window = SCAN_W'(r_chunk >> r_bit_ptr);
    w_lim    = 17'(SCAN_W);
    if (17'(c_chunk_bits) - 17'(r_bit_ptr) < w_lim) w_lim = 17'(c_chunk_bits) - 17'(r_bit_ptr);
    if ({1'b0, r_x_cols} - {1'b0, r_col} < w_lim)   w_lim = {1'b0, r_x_cols} - {1'b0, r_col};
    w_k   = '0;
    w_pop = '0;
    w_hit = 1'b0;
    for (int i = 0; i < SCAN_W; i++) begin
      if (!w_hit && 17'(i) < w_lim) begin
        w_k = w_k + c_bp_w'(1);
        if (w_window[i]) begin
          w_pop = w_pop + c_bc_w'(1);
          if (r_batch_cnt + w_pop == c_max_bc) w_hit = 1'b1;
        end
      end
    end
    w_scan_bp    = r_bit_ptr + w_k;
    w_scan_col   = r_col + 16'(w_k);
    w_scan_batch = r_batch_cnt + w_pop;
    w_flush      = (w_scan_batch == c_max_bc) || (w_scan_col == r_x_cols) ||
                   (w_scan_bp == c_chunk_bits);
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_row_nxt          = r_row;
    w_pass_nxt         = r_pass;
    w_col_nxt          = r_col;
    w_bit_ptr_nxt      = r_bit_ptr;
    w_nz_ptr_nxt       = r_nz_ptr;
    w_nz_row_start_nxt = r_nz_row_start;
    w_batch_cnt_nxt    = r_batch_cnt;
    w_adv              = 1'b0;
    w_adv_nz           = r_nz_ptr;
    unique case (r_state)
      S_IDLE: if (start_i) begin
        w_row_nxt          = '0;
        w_pass_nxt         = '0;
        w_col_nxt          = '0;
        w_bit_ptr_nxt      = '0;
        w_nz_ptr_nxt       = '0;
        w_nz_row_start_nxt = '0;
        w_batch_cnt_nxt    = '0;
        w_state_nxt = (x_rows_i == 16'd0 || x_cols_i == 16'd0 || y_row_iters_i == 16'd0)
                      ? S_DONE : S_META_REQ;
      end
      S_META_REQ: if (cfg_ready_i) begin
        w_bit_ptr_nxt = c_bp_w'(w_bit_addr[2:0]);
        w_state_nxt   = S_META_WAIT;
      end
      S_META_WAIT: if (meta_valid_i) w_state_nxt = S_SCAN;
      S_SCAN: begin
        w_bit_ptr_nxt   = w_scan_bp;
        w_col_nxt       = w_scan_col;
        w_batch_cnt_nxt = w_scan_batch;
        if (w_flush) begin
          if (w_scan_batch != '0)         w_state_nxt = S_DATA_REQ;
          else if (w_scan_col == r_x_cols) w_adv      = 1'b1;
          else                             w_state_nxt = S_META_REQ;
        end
      end
      S_DATA_REQ: if (cfg_ready_i) begin
        w_nz_ptr_nxt    = r_nz_ptr + 32'(r_batch_cnt);
        w_batch_cnt_nxt = '0;
        if (r_col == r_x_cols) begin
          w_adv    = 1'b1;
          w_adv_nz = r_nz_ptr + 32'(r_batch_cnt);
        end else if (r_bit_ptr == c_chunk_bits) begin
          w_state_nxt = S_META_REQ;
        end else begin
          w_state_nxt = S_SCAN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Rewind nonzeros for another pass of the same row, or commit them on the last pass.
    if (w_adv) begin
      w_col_nxt   = '0;
      w_state_nxt = S_META_REQ;
      if (r_pass + 16'd1 == r_y_iters) begin
        w_pass_nxt         = '0;
        w_row_nxt          = r_row + 16'd1;
        w_nz_row_start_nxt = w_adv_nz;
        w_nz_ptr_nxt       = w_adv_nz;
        if (r_row + 16'd1 == r_x_rows) w_state_nxt = S_DONE;
      end else begin
        w_pass_nxt   = r_pass + 16'd1;
        w_nz_ptr_nxt = r_nz_row_start;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || clear_i) begin
      r_state        <= S_IDLE;
      r_row          <= '0;
      r_pass         <= '0;
      r_col          <= '0;
      r_bit_ptr      <= '0;
      r_nz_ptr       <= '0;
      r_nz_row_start <= '0;
      r_batch_cnt    <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_row          <= w_row_nxt;
      r_pass         <= w_pass_nxt;
      r_col          <= w_col_nxt;
      r_bit_ptr      <= w_bit_ptr_nxt;
      r_nz_ptr       <= w_nz_ptr_nxt;
      r_nz_row_start <= w_nz_row_start_nxt;
      r_batch_cnt    <= w_batch_cnt_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta_base  <= '0;
      r_nz_base    <= '0;
      r_x_rows     <= '0;
      r_x_cols     <= '0;
      r_x_cols_log <= '0;
      r_y_iters    <= '0;
      r_chunk      <= '0;
    end else begin
      if (r_state == S_IDLE && start_i && !clear_i) begin
        r_meta_base  <= meta_base_i;
        r_nz_base    <= nz_base_i;
        r_x_rows     <= x_rows_i;
        r_x_cols     <= x_cols_i;
        r_x_cols_log <= x_cols_log_i;
        r_y_iters    <= y_row_iters_i;
      end
      if (r_state == S_META_WAIT && meta_valid_i) r_chunk <= meta_chunk_i;
    end
  end

  always_comb begin
    cfg_valid_o   = 1'b0;
    cfg_is_meta_o = 1'b0;
    cfg_addr_o    = '0;
    cfg_len_o     = '0;
    cfg_stride_o  = '0;
    case (r_state)
      S_META_REQ: begin
        cfg_valid_o   = 1'b1;
        cfg_is_meta_o = 1'b1;
        cfg_addr_o    = r_meta_base + (w_bit_addr >> 3);
        cfg_len_o     = 16'd1;
        cfg_stride_o  = (r_row == r_x_rows - 16'd1) ? w_last_stride : c_meta_bytes;
      end
      S_DATA_REQ: begin
        cfg_valid_o  = 1'b1;
        cfg_addr_o   = r_nz_base + r_nz_ptr * 32'(c_data_bytes);
        cfg_len_o    = 16'(r_batch_cnt);
        cfg_stride_o = c_data_bytes;
      end
      default: ;
    endcase
  end

  assign busy_o = (r_state != S_IDLE);
  assign done_o = (r_state == S_DONE);

`ifdef X_SCHED_PERF_EN
  logic [31:0] r_perf_meta, r_perf_data, r_perf_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_meta  <= '0;
      r_perf_data  <= '0;
      r_perf_stall <= '0;
    end else if (clear_i || (r_state == S_IDLE && start_i)) begin
      r_perf_meta  <= '0;
      r_perf_data  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (cfg_valid_o && cfg_ready_i && cfg_is_meta_o)  r_perf_meta  <= r_perf_meta + 32'd1;
      if (cfg_valid_o && cfg_ready_i && !cfg_is_meta_o) r_perf_data  <= r_perf_data + 32'd1;
      if (cfg_valid_o && !cfg_ready_i)                  r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_meta_req_o = r_perf_meta;
  assign perf_data_req_o = r_perf_data;
  assign perf_stall_o    = r_perf_stall;
`else
  assign perf_meta_req_o = '0;
  assign perf_data_req_o = '0;
  assign perf_stall_o    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_x_bitmap_stream_scheduler.sv
`default_nettype none
// Testbench for x_bitmap_stream_scheduler: directed table, hand sequences and
// randomized jobs checked against a request-list reference model.
module tb_x_bitmap_stream_scheduler;
  localparam int MCS       = 32;
  localparam int MAX_ELEMS = 4;
  localparam int NZ_BYTES  = 4;
  localparam int MEM_BITS  = 2048;

  logic        clk = 1'b0, rst_ni = 1'b0, clear = 1'b0, start = 1'b0;
  logic [31:0] meta_base = '0, nz_base = '0;
  logic [15:0] x_rows = '0, x_cols = '0, iters = '0;
  logic [4:0]  x_log = '0;
  logic        meta_valid = 1'b0, cfg_ready = 1'b0;
  logic [31:0] meta_chunk = '0;
  logic        cfg_valid, cfg_is_meta, busy, done;
  logic [31:0] cfg_addr, perf_meta, perf_data, perf_stall;
  logic [15:0] cfg_len, cfg_stride;

  x_bitmap_stream_scheduler dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .start_i(start),
    .meta_base_i(meta_base), .nz_base_i(nz_base), .x_rows_i(x_rows), .x_cols_i(x_cols),
    .x_cols_log_i(x_log), .y_row_iters_i(iters), .meta_valid_i(meta_valid),
    .meta_chunk_i(meta_chunk), .cfg_valid_o(cfg_valid), .cfg_ready_i(cfg_ready),
    .cfg_is_meta_o(cfg_is_meta), .cfg_addr_o(cfg_addr), .cfg_len_o(cfg_len),
    .cfg_stride_o(cfg_stride), .busy_o(busy), .done_o(done),
    .perf_meta_req_o(perf_meta), .perf_data_req_o(perf_data), .perf_stall_o(perf_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_meta;
    logic [31:0] addr;
    logic [15:0] len;
    logic [15:0] stride;
  } req_t;

  typedef struct {
    int rows, cols, lg, iters, fill;
    int e_meta, e_data, e_nz;
  } vec_t;

  int   n_vec = 0, n_err = 0;
  bit   mem [0:MEM_BITS-1];
  req_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill_mem(input int mode);
    logic [7:0] b5 = 8'hB5;
    for (int i = 0; i < MEM_BITS; i++) begin
      case (mode)
        0:       mem[i] = (i < 8) ? b5[i] : 1'b0;
        1:       mem[i] = 1'b1;
        2:       mem[i] = (i >= 32);
        default: mem[i] = ($urandom_range(99) < 45);
      endcase
    end
  endtask

  function automatic logic [31:0] read_chunk(input logic [31:0] addr, input logic [31:0] mb);
    logic [31:0] c = '0;
    longint base = longint'(addr - mb) * 8;
    for (int j = 0; j < MCS; j++)
      if (base + j < MEM_BITS) c[j] = mem[int'(base + j)];
    return c;
  endfunction

  // Expected request list: each row pass walks the row chunk by chunk; nonzeros
  // inside a chunk are grouped into batches of at most MAX_ELEMS.
  task automatic build_expected(input int rows, cols, lg, its, input logic [31:0] mb, nb);
    int unsigned nz = 0, row_start = 0;
    exp_q.delete();
    if (rows == 0 || cols == 0 || its == 0) return;
    for (int r = 0; r < rows; r++) begin
      for (int p = 0; p < its; p++) begin
        int col = 0;
        nz = row_start;
        while (col < cols) begin
          int ba = (r << lg) + col;
          int off = ba % 8;
          int end_c = (col + MCS - off < cols) ? col + MCS - off : cols;
          int strd = MCS / 8;
          int cnt = 0;
          if (r == rows - 1 && (off + cols - col + 7) / 8 < strd) strd = (off + cols - col + 7) / 8;
          exp_q.push_back('{1'b1, mb + 32'(ba / 8), 16'd1, 16'(strd)});
          for (int c = col; c < end_c; c++) begin
            if (mem[ba + c - col]) cnt++;
            if (cnt == MAX_ELEMS) begin
              exp_q.push_back('{1'b0, nb + nz * NZ_BYTES, 16'(cnt), 16'(NZ_BYTES)});
              nz += cnt;
              cnt = 0;
            end
          end
          if (cnt > 0) begin
            exp_q.push_back('{1'b0, nb + nz * NZ_BYTES, 16'(cnt), 16'(NZ_BYTES)});
            nz += cnt;
          end
          col = end_c;
        end
      end
      row_start = nz;
    end
  endtask

  // Runs one job from a negedge: random ready, delayed metadata replies, stray meta pulses.
  task automatic run_job(input int rows, cols, lg, its, input logic [31:0] mb, nb,
                         input int rdy_pct, spur_pct, output int n_meta, n_data, n_nz);
    int pend = -1;
    logic [31:0] pend_addr = '0;
    bit prev_stall = 0, got_done = 0;
    logic [31:0] h_addr = '0;
    logic [31:0] h_ls = '0;
    logic h_meta = 1'b0;
    req_t e;
    n_meta = 0; n_data = 0; n_nz = 0;
    build_expected(rows, cols, lg, its, mb, nb);
    meta_base = mb; nz_base = nb; x_rows = 16'(rows); x_cols = 16'(cols);
    x_log = 5'(lg); iters = 16'(its); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    meta_base = $urandom; nz_base = $urandom; x_rows = 16'($urandom);
    x_cols = 16'($urandom); x_log = 5'($urandom); iters = 16'($urandom);
    if (exp_q.size() > 0) check("start_latency", {62'd0, busy, cfg_valid}, 64'd3);
    else                  check("empty_job_done", {62'd0, busy, done}, 64'd3);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (done) begin got_done = 1; break; end
      if (prev_stall) begin
        check("hold_valid", {62'd0, cfg_valid, cfg_is_meta}, {62'd0, 1'b1, h_meta});
        check("hold_addr", cfg_addr, h_addr);
        check("hold_len_stride", {cfg_len, cfg_stride}, h_ls);
      end
      meta_valid = 1'b0;
      if (pend == 0) begin
        meta_valid = 1'b1; meta_chunk = read_chunk(pend_addr, mb); pend = -1;
      end else if (pend > 0) begin
        pend--;
      end else if ($urandom_range(99) < spur_pct) begin
        meta_valid = 1'b1; meta_chunk = $urandom;
      end
      cfg_ready = ($urandom_range(99) < rdy_pct);
      if (cfg_valid && cfg_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL extra_req: got addr 0x%0h len %0d, expected no request", cfg_addr, cfg_len);
        end else begin
          e = exp_q.pop_front();
          check("req_is_meta", {63'd0, cfg_is_meta}, {63'd0, e.is_meta});
          check("req_addr", cfg_addr, e.addr);
          check("req_len", cfg_len, e.len);
          check("req_stride", cfg_stride, e.stride);
        end
        if (cfg_is_meta) begin
          n_meta++; pend = $urandom_range(3); pend_addr = cfg_addr;
        end else begin
          n_data++; n_nz += int'(cfg_len);
        end
      end
      prev_stall = cfg_valid && !cfg_ready;
      h_addr = cfg_addr; h_ls = {cfg_len, cfg_stride}; h_meta = cfg_is_meta;
      @(negedge clk);
    end
    meta_valid = 1'b0;
    cfg_ready  = 1'b0;
    if (!got_done) begin
      n_vec++; n_err++;
      $display("FAIL job_timeout: got no done_o, expected done_o within budget");
    end else begin
      check("done_busy", {63'd0, busy}, 64'd1);
      @(negedge clk);
      check("done_one_cycle", {61'd0, done, busy, cfg_valid}, 64'd0);
    end
    check("missing_reqs", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!cfg_valid && k < 20) begin @(negedge clk); k++; end
    if (!cfg_valid) begin
      n_vec++; n_err++;
      $display("FAIL %s: got no cfg_valid_o, expected a request within 20 cycles", name);
    end
  endtask

  task automatic start_sc1();
    fill_mem(0);
    meta_base = 32'h1000; nz_base = 32'h2000; x_rows = 16'd1; x_cols = 16'd8;
    x_log = 5'd3; iters = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  vec_t tbl [8];

  initial begin
    int nm, nd, nn;
    tbl[0] = '{1, 8,  3, 1, 0, 1, 2,  5};
    tbl[1] = '{1, 8,  3, 2, 0, 2, 4,  10};
    tbl[2] = '{2, 64, 6, 1, 1, 4, 32, 128};
    tbl[3] = '{1, 64, 6, 1, 2, 2, 8,  32};
    tbl[4] = '{0, 8,  3, 1, 0, 0, 0,  0};
    tbl[5] = '{1, 8,  3, 0, 0, 0, 0,  0};
    tbl[6] = '{1, 0,  3, 1, 0, 0, 0,  0};
    tbl[7] = '{2, 12, 4, 1, 1, 2, 6,  24};

    #12;
    check("reset_cfg", {cfg_valid, cfg_is_meta, cfg_addr, cfg_len, cfg_stride[13:0]}, 64'd0);
    check("reset_stride_status", {60'd0, cfg_stride[15:14], busy, done}, 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      fill_mem(tbl[i].fill);
      run_job(tbl[i].rows, tbl[i].cols, tbl[i].lg, tbl[i].iters, 32'h1000, 32'h2000,
              70, 10, nm, nd, nn);
      check("tbl_meta_count", 64'(nm), 64'(tbl[i].e_meta));
      check("tbl_data_count", 64'(nd), 64'(tbl[i].e_data));
      check("tbl_nz_total", 64'(nn), 64'(tbl[i].e_nz));
    end

    // Backpressure held for five cycles on the first data request.
    cfg_ready = 1'b1;
    start_sc1();
    check("sc1_meta", {cfg_valid, cfg_is_meta, cfg_addr, cfg_len[7:0], cfg_stride[7:0]},
          {1'b1, 1'b1, 32'h1000, 8'd1, 8'd1});
    @(negedge clk);
    meta_valid = 1'b1; meta_chunk = read_chunk(32'h1000, 32'h1000);
    @(negedge clk);
    meta_valid = 1'b0; cfg_ready = 1'b0;
    wait_valid("sc1_data0_wait");
    check("sc1_data0", {cfg_is_meta, cfg_addr, cfg_len, cfg_stride}, {1'b0, 32'h2000, 16'd4, 16'd4});
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("stall_hold", {cfg_valid, cfg_is_meta, cfg_addr, cfg_len, cfg_stride[13:0]},
            {1'b1, 1'b0, 32'h2000, 16'd4, 14'd4});
    end
    cfg_ready = 1'b1;
    @(negedge clk);
    wait_valid("sc1_data1_wait");
    check("sc1_data1", {cfg_is_meta, cfg_addr, cfg_len, cfg_stride}, {1'b0, 32'h2010, 16'd1, 16'd4});
    @(negedge clk);
    check("sc1_done", {62'd0, done, cfg_valid}, 64'd2);
    @(negedge clk);
    check("sc1_idle", {62'd0, done, busy}, 64'd0);
`ifdef X_SCHED_PERF_EN
    check("perf_stall", perf_stall, 64'd5);
    check("perf_counts", {perf_meta, perf_data}, {32'd1, 32'd2});
`else
    check("perf_tied_off", {perf_stall, perf_meta | perf_data}, 64'd0);
`endif

    // Clear while scanning, then restart the same job.
    start_sc1();
    @(negedge clk);
    meta_valid = 1'b1; meta_chunk = read_chunk(32'h1000, 32'h1000); cfg_ready = 1'b0;
    @(negedge clk);
    meta_valid = 1'b0;
    check("scan_state", {62'd0, busy, cfg_valid}, 64'd2);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_idle", {61'd0, busy, cfg_valid, done}, 64'd0);
    check("clear_fields", {cfg_addr, cfg_len, cfg_stride}, 64'd0);
    fill_mem(0);
    run_job(1, 8, 3, 1, 32'h1000, 32'h2000, 100, 0, nm, nd, nn);
    check("restart_counts", {nm[15:0], nd[15:0], nn[15:0]}, {16'd1, 16'd2, 16'd5});

    for (int j = 0; j < 12; j++) begin
      int lg = $urandom_range(7, 3);
      int cols = $urandom_range(1 << lg, 1);
      int rows = $urandom_range(3, 1);
      int its = $urandom_range(3, 1);
      fill_mem(3);
      run_job(rows, cols, lg, its, $urandom, $urandom, $urandom_range(100, 50), 15, nm, nd, nn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
